// File: rtl/riscv_checkpoint_monitor_if.sv
// Signal bundle between a RISC-V core test harness and the checkpoint monitor.
// The harness (master) loads the checkpoint table, arms a run and presents the
// observed core state. The monitor (slave) reports run status and diagnostics.
interface riscv_checkpoint_monitor_if #(
  parameter int DWIDTH = 32,
  parameter int IDX_W  = 5
);
  // Checkpoint table write port
  logic              LD_EN;
  logic [IDX_W-1:0]  LD_IDX;
  logic [31:0]       LD_NINST;
  logic [DWIDTH-1:0] LD_ANS;
  // Run control
  logic              START;
  logic [IDX_W:0]    NUM_VALID;
  // Observed core state
  logic [31:0]       NUM_INST;
  logic [DWIDTH-1:0] OUTPUT_PORT;
  logic              HALT;
  // Status and diagnostics
  logic              BUSY;
  logic              PASS;
  logic              FAIL;
  logic              TIMEOUT;
  logic [IDX_W-1:0]  FAIL_IDX;
  logic [DWIDTH-1:0] FAIL_VAL;
  logic [31:0]       CYCLE;
  logic [IDX_W:0]    CHK_DONE;

  modport master (
    output LD_EN, LD_IDX, LD_NINST, LD_ANS, START, NUM_VALID,
           NUM_INST, OUTPUT_PORT, HALT,
    input  BUSY, PASS, FAIL, TIMEOUT, FAIL_IDX, FAIL_VAL, CYCLE, CHK_DONE
  );

  modport slave (
    input  LD_EN, LD_IDX, LD_NINST, LD_ANS, START, NUM_VALID,
           NUM_INST, OUTPUT_PORT, HALT,
    output BUSY, PASS, FAIL, TIMEOUT, FAIL_IDX, FAIL_VAL, CYCLE, CHK_DONE
  );
endinterface

// File: rtl/riscv_checkpoint_monitor.sv
// Checkpoint monitor for a RISC-V core under test. A table of
// {instruction count, expected output} pairs is walked in index order while
// the core runs; each entry is checked when the retired instruction count
// reaches it. The run ends in PASS on HALT with all entries matched, in FAIL on
// a mismatch, a skipped checkpoint or an early HALT, or in TIMEOUT when the
// optional watchdog expires.
// Build option: define CHK_WATCHDOG_EN to compile the TIMEOUT_CYC watchdog.
module riscv_checkpoint_monitor #(
  parameter int DWIDTH      = 32,
  parameter int NUM_CHK     = 32,
  parameter int IDX_W       = 5,
  parameter int TIMEOUT_CYC = 1000000
) (
  input logic                    CLK,
  input logic                    RSTn,
  riscv_checkpoint_monitor_if.slave bus
);

  localparam int PW = IDX_W + 1;

  typedef enum logic [2:0] {IDLE, RUN, S_PASS, S_FAIL, S_TMO} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     nvalid_q, nvalid_d;
  logic [31:0]       cycle_q, cycle_d;
  logic [IDX_W-1:0]  fail_idx_q, fail_idx_d;
  logic [DWIDTH-1:0] fail_val_q, fail_val_d;
  logic              busy_q, pass_q, fail_q, tmo_q;

  logic [31:0]       tbl_ninst [NUM_CHK];
  logic [DWIDTH-1:0] tbl_ans   [NUM_CHK];

  logic [IDX_W-1:0]  ptr_idx;
  logic [31:0]       cur_ninst;
  logic [DWIDTH-1:0] cur_ans;
  logic              chk_active, at_chk, hit, bad, tmo_hit;
  logic [PW-1:0]     ptr_adv, nvalid_clamp;

  assign ptr_idx   = ptr_q[IDX_W-1:0];
  assign cur_ninst = tbl_ninst[ptr_idx];
  assign cur_ans   = tbl_ans[ptr_idx];

  // A checkpoint is evaluated only while entries remain; reaching its count
  // compares the output, overshooting it means the checkpoint was skipped.
  assign chk_active   = (ptr_q < nvalid_q);
  assign at_chk       = chk_active && (bus.NUM_INST == cur_ninst);
  assign hit          = at_chk && (bus.OUTPUT_PORT == cur_ans);
  assign bad          = (at_chk && (bus.OUTPUT_PORT != cur_ans)) ||
                        (chk_active && (bus.NUM_INST > cur_ninst));
  assign ptr_adv      = hit ? ptr_q + PW'(1) : ptr_q;
  assign nvalid_clamp = (bus.NUM_VALID > PW'(NUM_CHK)) ? PW'(NUM_CHK) : bus.NUM_VALID;

`ifdef CHK_WATCHDOG_EN
  assign tmo_hit = (cycle_q == 32'(TIMEOUT_CYC - 1));
`else
  // Watchdog compiled out: TIMEOUT_CYC is kept only so both builds share one
  // parameter list.
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = (TIMEOUT_CYC != 0);
  assign tmo_hit = 1'b0;
`endif

  // Table write port, blocked while a run is walking the table.
  // NOTE: the table has no reset on purpose; a reset must not wipe a loaded
  // test program's checkpoints, and resetting an array forbids RAM mapping.
  always_ff @(posedge CLK) begin
    if (bus.LD_EN && (state_q != RUN) && (int'(bus.LD_IDX) < NUM_CHK)) begin
      tbl_ninst[bus.LD_IDX] <= bus.LD_NINST;
      tbl_ans[bus.LD_IDX]   <= bus.LD_ANS;
    end
  end

  // Next-state logic: arm, checkpoint walk and run termination with
  // priority mismatch/skip > timeout > HALT.
  // NOTE: every _d gets a default before the case so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    nvalid_d   = nvalid_q;
    cycle_d    = cycle_q;
    fail_idx_d = fail_idx_q;
    fail_val_d = fail_val_q;
    case (state_q)
      RUN: begin
        cycle_d = (cycle_q == '1) ? cycle_q : cycle_q + 32'd1;
        if (bad) begin
          state_d    = S_FAIL;
          fail_idx_d = ptr_idx;
          fail_val_d = bus.OUTPUT_PORT;
        end else begin
          ptr_d = ptr_adv;
          if (tmo_hit) begin
            state_d = S_TMO;
          end else if (bus.HALT) begin
            if (ptr_adv == nvalid_q) begin
              state_d = S_PASS;
            end else begin
              state_d    = S_FAIL;
              fail_idx_d = ptr_adv[IDX_W-1:0];
              fail_val_d = bus.OUTPUT_PORT;
            end
          end
        end
      end
      default: begin
        if (bus.START) begin
          state_d    = RUN;
          nvalid_d   = nvalid_clamp;
          ptr_d      = '0;
          cycle_d    = '0;
          fail_idx_d = '0;
          fail_val_d = '0;
        end
      end
    endcase
  end

  // State and registered status flags; synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values computed above.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      nvalid_q   <= '0;
      cycle_q    <= '0;
      fail_idx_q <= '0;
      fail_val_q <= '0;
      busy_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      nvalid_q   <= nvalid_d;
      cycle_q    <= cycle_d;
      fail_idx_q <= fail_idx_d;
      fail_val_q <= fail_val_d;
      busy_q     <= (state_d == RUN);
      pass_q     <= (state_d == S_PASS);
      fail_q     <= (state_d == S_FAIL);
      tmo_q      <= (state_d == S_TMO);
    end
  end

  assign bus.BUSY     = busy_q;
  assign bus.PASS     = pass_q;
  assign bus.FAIL     = fail_q;
  assign bus.TIMEOUT  = tmo_q;
  assign bus.FAIL_IDX = fail_idx_q;
  assign bus.FAIL_VAL = fail_val_q;
  assign bus.CYCLE    = cycle_q;
  assign bus.CHK_DONE = ptr_q;

endmodule
